// File: rtl/prbs_checker_if.sv
// Byte-stream and status bundle between a PRBS source and prbs_checker.
// The source drives the byte side; the checker drives the status side.
`default_nettype none

interface prbs_checker_if #(
   parameter int ERR_CNT_W = 16
);
   logic                 data_valid;
   logic [31:0]          in;
   logic [7:0]           n;
   logic [7:0]           rx_byte;
   logic                 pattern_ok;
   logic                 pattern_err;
   logic                 prbs_locked;
   logic                 prbs_err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output data_valid, in, n, rx_byte,
      input  pattern_ok, pattern_err, prbs_locked, prbs_err, err_cnt
   );

   modport slave (
      input  data_valid, in, n, rx_byte,
      output pattern_ok, pattern_err, prbs_locked, prbs_err, err_cnt
   );
endinterface

`default_nettype wire

// File: rtl/prbs_checker.sv
// Pattern-then-PRBS-15 receive checker with a self-synchronising LFSR.
// Optional macro PRBS_CHECK_RESYNC_EN drops lock after RESYNC_THR consecutive bad bytes.
`default_nettype none

module prbs_checker #(
   parameter int ERR_CNT_W  = 16,
   parameter int RESYNC_THR = 8
) (
   input  logic          clk,
   input  logic          rst,
   prbs_checker_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PATTERN = 3'd1,
      S_SYNC    = 3'd2,
      S_CHECK   = 3'd3,
      S_FAIL    = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          pat_q, pat_d;
   logic [7:0]           n_q, n_d;
   logic [1:0]           idx_q, idx_d;
   logic [7:0]           rep_q, rep_d;
   logic [6:0]           b0_q, b0_d;
   logic                 have_b0_q, have_b0_d;
   logic [14:0]          lfsr_q, lfsr_d;
   logic                 pattern_ok_q, pattern_ok_d;
   logic                 pattern_err_q, pattern_err_d;
   logic                 locked_q, locked_d;
   logic                 prbs_err_q, prbs_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

`ifdef PRBS_CHECK_RESYNC_EN
   localparam int RUN_W = $clog2(RESYNC_THR + 1);
   logic [RUN_W-1:0] run_q, run_d;
`endif

   logic [7:0] w_pat_byte;
   logic [7:0] w_pred;

   // Predicted bits only depend on bits 14+ positions back, i.e. on prior bytes,
   // but the received bits are still shifted in so the predictor self-synchronises.
   function automatic logic [7:0] predict(input logic [14:0] seed, input logic [7:0] rx);
      logic [14:0] s;
      logic [7:0]  p;
      s = seed;
      p = 8'd0;
      for (int i = 7; i >= 0; i--) begin
         p[i] = s[14] ^ s[13];
         s    = {s[13:0], rx[i]};
      end
      return p;
   endfunction

   always_comb begin
      case (idx_q)
         2'd0:    w_pat_byte = pat_q[31:24];
         2'd1:    w_pat_byte = pat_q[23:16];
         2'd2:    w_pat_byte = pat_q[15:8];
         default: w_pat_byte = pat_q[7:0];
      endcase
   end

   assign w_pred = predict(lfsr_q, bus.rx_byte);

   always_comb begin
      state_d       = state_q;
      pat_d         = pat_q;
      n_d           = n_q;
      idx_d         = idx_q;
      rep_d         = rep_q;
      b0_d          = b0_q;
      have_b0_d     = have_b0_q;
      lfsr_d        = lfsr_q;
      pattern_ok_d  = pattern_ok_q;
      pattern_err_d = pattern_err_q;
      locked_d      = locked_q;
      prbs_err_d    = 1'b0;
      err_cnt_d     = err_cnt_q;
`ifdef PRBS_CHECK_RESYNC_EN
      run_d         = run_q;
`endif

      if (bus.data_valid) begin
         case (state_q)
            S_IDLE: begin
               pat_d = bus.in;
               n_d   = bus.n;
               if (bus.n == 8'd0) begin
                  b0_d      = bus.rx_byte[6:0];
                  have_b0_d = 1'b1;
                  state_d   = S_SYNC;
               end else if (bus.rx_byte != bus.in[31:24]) begin
                  pattern_err_d = 1'b1;
                  state_d       = S_FAIL;
               end else begin
                  idx_d   = 2'd1;
                  rep_d   = 8'd0;
                  state_d = S_PATTERN;
               end
            end

            S_PATTERN: begin
               if (bus.rx_byte != w_pat_byte) begin
                  pattern_err_d = 1'b1;
                  state_d       = S_FAIL;
               end else if (idx_q == 2'd3 && rep_q == n_q - 8'd1) begin
                  pattern_ok_d = 1'b1;
                  have_b0_d    = 1'b0;
                  state_d      = S_SYNC;
               end else begin
                  idx_d = idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     rep_d = rep_q + 8'd1;
                  end
               end
            end

            S_SYNC: begin
               if (!have_b0_q) begin
                  b0_d      = bus.rx_byte[6:0];
                  have_b0_d = 1'b1;
               end else begin
                  lfsr_d    = {b0_q, bus.rx_byte};
                  locked_d  = 1'b1;
                  have_b0_d = 1'b0;
                  state_d   = S_CHECK;
               end
            end

            S_CHECK: begin
               lfsr_d = {lfsr_q[6:0], bus.rx_byte};
               if (w_pred != bus.rx_byte) begin
                  prbs_err_d = 1'b1;
                  if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
`ifdef PRBS_CHECK_RESYNC_EN
                  if (run_q == RUN_W'(RESYNC_THR - 1)) begin
                     run_d     = '0;
                     locked_d  = 1'b0;
                     have_b0_d = 1'b0;
                     state_d   = S_SYNC;
                  end else begin
                     run_d = run_q + 1'b1;
                  end
`endif
               end else begin
`ifdef PRBS_CHECK_RESYNC_EN
                  run_d = '0;
`endif
               end
            end

            S_FAIL: begin
               state_d = S_FAIL;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         pat_q         <= 32'd0;
         n_q           <= 8'd0;
         idx_q         <= 2'd0;
         rep_q         <= 8'd0;
         b0_q          <= 7'd0;
         have_b0_q     <= 1'b0;
         lfsr_q        <= 15'd0;
         pattern_ok_q  <= 1'b0;
         pattern_err_q <= 1'b0;
         locked_q      <= 1'b0;
         prbs_err_q    <= 1'b0;
         err_cnt_q     <= '0;
`ifdef PRBS_CHECK_RESYNC_EN
         run_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pat_q         <= pat_d;
         n_q           <= n_d;
         idx_q         <= idx_d;
         rep_q         <= rep_d;
         b0_q          <= b0_d;
         have_b0_q     <= have_b0_d;
         lfsr_q        <= lfsr_d;
         pattern_ok_q  <= pattern_ok_d;
         pattern_err_q <= pattern_err_d;
         locked_q      <= locked_d;
         prbs_err_q    <= prbs_err_d;
         err_cnt_q     <= err_cnt_d;
`ifdef PRBS_CHECK_RESYNC_EN
         run_q         <= run_d;
`endif
      end
   end

   assign bus.pattern_ok  = pattern_ok_q;
   assign bus.pattern_err = pattern_err_q;
   assign bus.prbs_locked = locked_q;
   assign bus.prbs_err    = prbs_err_q;
   assign bus.err_cnt     = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with a bit-history reference model.
`default_nettype none

module tb_prbs_checker;
   localparam int ERR_CNT_W  = 16;
   localparam int RESYNC_THR = 8;
   localparam int PH_IDLE = 0, PH_PAT = 1, PH_SYNC = 2, PH_CHECK = 3, PH_FAIL = 4;

   logic clk;
   logic rst;
   prbs_checker_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

   prbs_checker #(.ERR_CNT_W(ERR_CNT_W), .RESYNC_THR(RESYNC_THR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   // reference model state
   int          m_phase;
   logic [31:0] m_pat;
   int          m_n;
   int          m_cnt;
   bit          m_bits[$];
   int          m_run;
   int          m_errs;
   logic        exp_ok, exp_perr, exp_lock, exp_pe;
   longint      exp_cnt;

   logic [7:0]  stream[$];
   logic [7:0]  prbs[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE; m_pat = 0; m_n = 0; m_cnt = 0; m_bits.delete();
      m_run = 0; m_errs = 0;
      exp_ok = 0; exp_perr = 0; exp_lock = 0; exp_pe = 0; exp_cnt = 0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) m_bits.push_back(b[i]);
      while (m_bits.size() > 40) void'(m_bits.pop_front());
   endtask

   // Next PRBS-15 byte from history: bit[t] = bit[t-15] ^ bit[t-14].
   function automatic logic [7:0] pred_byte();
      logic [7:0] p;
      int j;
      for (int i = 0; i < 8; i++) begin
         j = m_bits.size() + i;
         p[7-i] = m_bits[j-15] ^ m_bits[j-14];
      end
      return p;
   endfunction

   task automatic pattern_byte(input logic [7:0] b);
      logic [7:0] e;
      e = 8'((m_pat >> (8 * (3 - (m_cnt % 4)))) & 32'hFF);
      if (b != e) begin
         exp_perr = 1; m_phase = PH_FAIL;
      end else begin
         m_cnt++;
         if (m_cnt == 4 * m_n) begin
            exp_ok = 1; m_phase = PH_SYNC; m_bits.delete();
         end
      end
   endtask

   task automatic check_byte(input logic [7:0] b);
      bit bad;
      bad = (b != pred_byte());
      push_byte(b);
      if (bad) begin
         exp_pe = 1;
         m_errs++;
         if (exp_cnt < (longint'(1) << ERR_CNT_W) - 1) exp_cnt++;
`ifdef PRBS_CHECK_RESYNC_EN
         m_run++;
         if (m_run == RESYNC_THR) begin
            m_run = 0; exp_lock = 0; m_phase = PH_SYNC; m_bits.delete();
         end
`endif
      end else begin
         m_run = 0;
      end
   endtask

   task automatic model_step(input logic v, input logic [7:0] b);
      exp_pe = 0;
      if (!rst) begin
         model_reset();
      end else if (v) begin
         case (m_phase)
            PH_IDLE: begin
               m_pat = bus.in;
               m_n   = int'(bus.n);
               if (m_n == 0) begin
                  m_phase = PH_SYNC; m_bits.delete(); push_byte(b);
               end else begin
                  m_cnt = 0; m_phase = PH_PAT; pattern_byte(b);
               end
            end
            PH_PAT: pattern_byte(b);
            PH_SYNC: begin
               push_byte(b);
               if (m_bits.size() == 16) begin
                  exp_lock = 1; m_phase = PH_CHECK;
               end
            end
            PH_CHECK: check_byte(b);
            default: ;
         endcase
      end
   endtask

   task automatic cycle(input logic v, input logic [7:0] b);
      bus.data_valid = v;
      bus.rx_byte    = b;
      @(posedge clk);
      #1;
      model_step(v, b);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      cycle(1'b1, 8'hAB);
      cycle(1'b0, 8'h00);
      cycle(1'b1, 8'h5A);
      rst = 1'b1;
   endtask

   task automatic gen_prbs(input int nbytes);
      bit b[$];
      logic [14:0] seed;
      logic [7:0]  v;
      seed = 15'h5A3C;
      prbs.delete();
      for (int i = 14; i >= 0; i--) b.push_back(seed[i]);
      while (b.size() < nbytes * 8) b.push_back(b[b.size()-15] ^ b[b.size()-14]);
      for (int k = 0; k < nbytes; k++) begin
         for (int i = 0; i < 8; i++) v[7-i] = b[k*8+i];
         prbs.push_back(v);
      end
   endtask

   task automatic build_nominal();
      logic [7:0] pat[4];
      pat[0] = 8'hAB; pat[1] = 8'hCD; pat[2] = 8'hEF; pat[3] = 8'hAB;
      stream.delete();
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < 4; i++) stream.push_back(pat[i]);
      gen_prbs(50);
      foreach (prbs[k]) stream.push_back(prbs[k]);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pattern_ok",  longint'(bus.pattern_ok),  longint'(exp_ok));
         chk("pattern_err", longint'(bus.pattern_err), longint'(exp_perr));
         chk("prbs_locked", longint'(bus.prbs_locked), longint'(exp_lock));
         chk("prbs_err",    longint'(bus.prbs_err),    longint'(exp_pe));
         chk("err_cnt",     longint'(bus.err_cnt),     exp_cnt);
      end
   end

   initial begin
      logic [7:0] tmp;
      int e0;
      rst = 1'b0;
      bus.data_valid = 1'b0;
      bus.rx_byte    = 8'h00;
      bus.in         = 32'hABCDEFAB;
      bus.n          = 8'd3;
      model_reset();
      cycle(1'b0, 8'h00);
      chk_en = 1;

      // reset with toggling valid, then idle after release
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 8'hAB);
      chk("rst_idle_ok",   longint'(bus.pattern_ok),  0);
      chk("rst_idle_lock", longint'(bus.prbs_locked), 0);

      // nominal run
      build_nominal();
      foreach (stream[i]) begin
         cycle(1'b1, stream[i]);
         if (i == 10) chk("nom_ok_before", longint'(bus.pattern_ok), 0);
         if (i == 11) chk("nom_ok_after",  longint'(bus.pattern_ok), 1);
         if (i == 12) chk("nom_lock_b13",  longint'(bus.prbs_locked), 0);
         if (i == 13) chk("nom_lock_b14",  longint'(bus.prbs_locked), 1);
         if (i == 20) bus.in = 32'h00000000;
      end
      chk("nom_err_cnt", longint'(bus.err_cnt), 0);
      bus.in = 32'hABCDEFAB;

      // pattern byte 6 corrupted
      do_reset();
      build_nominal();
      stream[6] = 8'hEE;
      foreach (stream[i]) begin
         cycle(1'b1, stream[i]);
         if (i == 5) chk("perr_before", longint'(bus.pattern_err), 0);
         if (i == 6) chk("perr_after",  longint'(bus.pattern_err), 1);
      end
      chk("perr_ok_end",   longint'(bus.pattern_ok),  0);
      chk("perr_lock_end", longint'(bus.prbs_locked), 0);
      chk("perr_cnt_end",  longint'(bus.err_cnt),     0);

      // single bit error in PRBS byte 20
      do_reset();
      build_nominal();
      stream[12+20] = stream[12+20] ^ 8'h08;
      foreach (stream[i]) cycle(1'b1, stream[i]);
      chk("biterr_burst_range", longint'(bus.err_cnt >= 1 && bus.err_cnt <= 3), 1);
      chk("biterr_model_range", longint'(m_errs >= 1 && m_errs <= 3), 1);
      chk("biterr_lock_held",   longint'(bus.prbs_locked), 1);

      // n = 0 with gaps on every other cycle
      do_reset();
      bus.in = 32'h12345678;
      bus.n  = 8'd0;
      gen_prbs(30);
      foreach (prbs[i]) begin
         cycle(1'b1, prbs[i]);
         if (i == 0) chk("n0_lock_b1", longint'(bus.prbs_locked), 0);
         if (i == 1) chk("n0_lock_b2", longint'(bus.prbs_locked), 1);
         cycle(1'b0, ~prbs[i]);
         if (i == 1) chk("n0_lock_gap", longint'(bus.prbs_locked), 1);
      end
      chk("n0_ok",  longint'(bus.pattern_ok), 0);
      chk("n0_cnt", longint'(bus.err_cnt),    0);

`ifdef PRBS_CHECK_RESYNC_EN
      // every bit of each byte wrong forces RESYNC_THR consecutive bad bytes
      e0 = m_errs;
      for (int k = 0; k < RESYNC_THR; k++) begin
         tmp = ~pred_byte();
         cycle(1'b1, tmp);
         if (k == RESYNC_THR - 2) chk("rs_lock_before", longint'(bus.prbs_locked), 1);
      end
      chk("rs_lock_drop", longint'(bus.prbs_locked), 0);
      chk("rs_cnt_kept",  longint'(bus.err_cnt), longint'(e0 + RESYNC_THR));
      cycle(1'b1, prbs[3]);
      chk("rs_lock_b0", longint'(bus.prbs_locked), 0);
      cycle(1'b1, prbs[4]);
      chk("rs_lock_b1", longint'(bus.prbs_locked), 1);
      for (int k = 5; k < 15; k++) cycle(1'b1, prbs[k]);
      chk("rs_cnt_after", longint'(bus.err_cnt), longint'(e0 + RESYNC_THR));
`else
      e0 = 0;
      tmp = 8'h00;
`endif

      cycle(1'b0, 8'h00);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
